// File: rtl/stone_renderer.sv
// stone_renderer: once per frame, walks the item RAM, erases each item's
// previous 16x16 footprint when it moved or vanished, then redraws visible
// items as one-pixel-per-cycle plot commands for the VGA adapter.
module stone_renderer #(
  parameter int         FRAME_CLOCK   = 833_334,
  parameter logic [2:0] COLOR_BG      = 3'b000,
  parameter logic [2:0] COLOR_STONE   = 3'b111,
  parameter logic [2:0] COLOR_GOLD    = 3'b110,
  parameter logic [2:0] COLOR_DIAMOND = 3'b011
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic [3:0]  quantity,
  input  logic [31:0] data,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        done
);

  localparam int            CW   = (FRAME_CLOCK > 1) ? $clog2(FRAME_CLOCK) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CLOCK - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT, LATCH, ERASE, DRAW, NEXT, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] frame_count;
  logic          tick;
  logic [3:0]    index;
  logic [7:0]    pix_count;

  // Entry register, loaded in LATCH.
  logic [8:0] ent_x;
  logic [7:0] ent_y;
  logic [1:0] ent_type;
  logic       ent_visible;

  // Position last drawn for each index.
  logic       shadow_valid [16];
  logic [8:0] shadow_x     [16];
  logic [7:0] shadow_y     [16];

  // Fields of the RAM word as seen during LATCH.
  logic [8:0] new_x;
  logic [7:0] new_y;
  logic       new_visible;
  logic       need_erase;
  logic       unused_bits;

  assign new_x       = data[31:23];
  assign new_y       = data[18:11];
  assign new_visible = data[1];
  // The moving bit and padding fields carry nothing the renderer needs.
  assign unused_bits = ^{data[22:19], data[10:4], data[0]};
  assign need_erase  = shadow_valid[index] &&
                       (!new_visible || new_x != shadow_x[index] || new_y != shadow_y[index]);

  logic [8:0] base_x;
  logic [7:0] base_y;
  logic [2:0] pix_colour;
  logic [9:0] sum_x;
  logic [9:0] sum_y;
  logic       on_screen;

  // Pixel address/colour for the current ERASE or DRAW step; 10-bit sums avoid wraparound in the clip test.
  always_comb begin
    base_x = ent_x;
    base_y = ent_y;
    case (ent_type)
      2'b00:   pix_colour = COLOR_STONE;
      2'b01:   pix_colour = COLOR_GOLD;
      default: pix_colour = COLOR_DIAMOND;
    endcase
    if (state == ERASE) begin
      base_x     = shadow_x[index];
      base_y     = shadow_y[index];
      pix_colour = COLOR_BG;
    end
    sum_x     = {1'b0, base_x} + {6'b0, pix_count[3:0]};
    sum_y     = {2'b0, base_y} + {6'b0, pix_count[7:4]};
    on_screen = (sum_x < 10'd320) && (sum_y < 10'd240);
  end

  // Frame timer: runs only while enabled; tick is a registered one-cycle pulse
  // in the cycle after the counter reaches its terminal value.
  always_ff @(posedge clock) begin
    if (!resetn || !enable) begin
      frame_count <= '0;
      tick        <= 1'b0;
    end else if (frame_count == LAST) begin
      frame_count <= '0;
      tick        <= 1'b1;
    end else begin
      frame_count <= frame_count + CW'(1);
      tick        <= 1'b0;
    end
  end

  // Pass sequencer with registered outputs; ticks outside IDLE are dropped.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= IDLE;
      draw_stone_flag <= 1'b0;
      draw_index      <= 4'd0;
      vga_x           <= 9'd0;
      vga_y           <= 8'd0;
      colour          <= 3'd0;
      plot            <= 1'b0;
      done            <= 1'b0;
      index           <= 4'd0;
      pix_count       <= 8'd0;
      ent_x           <= 9'd0;
      ent_y           <= 8'd0;
      ent_type        <= 2'd0;
      ent_visible     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        shadow_valid[i] <= 1'b0;
        shadow_x[i]     <= 9'd0;
        shadow_y[i]     <= 8'd0;
      end
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            index <= 4'd0;
            if (quantity == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state           <= ADDR;
              draw_stone_flag <= 1'b1;
            end
          end
        end
        ADDR: begin
          draw_index <= index;
          state      <= WAIT;
        end
        WAIT: state <= LATCH;
        LATCH: begin
          ent_x       <= new_x;
          ent_y       <= new_y;
          ent_type    <= data[3:2];
          ent_visible <= new_visible;
          pix_count   <= 8'd0;
          // Position is kept so the erase below still knows where to clear.
          if (!new_visible) shadow_valid[index] <= 1'b0;
          if (need_erase)       state <= ERASE;
          else if (new_visible) state <= DRAW;
          else                  state <= NEXT;
        end
        ERASE, DRAW: begin
          vga_x     <= sum_x[8:0];
          vga_y     <= sum_y[7:0];
          colour    <= pix_colour;
          plot      <= on_screen;
          pix_count <= pix_count + 8'd1;
          if (pix_count == 8'hFF) begin
            if (state == DRAW) begin
              shadow_valid[index] <= 1'b1;
              shadow_x[index]     <= ent_x;
              shadow_y[index]     <= ent_y;
              state               <= NEXT;
            end else begin
              state <= ent_visible ? DRAW : NEXT;
            end
          end
        end
        NEXT: begin
          if (({1'b0, index} + 5'd1) < {1'b0, quantity}) begin
            index <= index + 4'd1;
            state <= ADDR;
          end else begin
            draw_stone_flag <= 1'b0;
            done            <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stone_renderer.sv
// Testbench for stone_renderer: a RAM model feeds entries, every expected
// plot is queued when a frame is set up and popped as the DUT plots it.
module tb_stone_renderer;
  localparam int FC = 2000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  quantity = 4'd0;
  logic [31:0] data = 32'd0;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  colour;
  logic        plot;
  logic        done;

  stone_renderer #(.FRAME_CLOCK(FC)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .quantity(quantity),
    .data(data), .draw_stone_flag(draw_stone_flag), .draw_index(draw_index),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  // Item RAM with one cycle of read latency behind the registered address.
  logic [31:0] mem [16];
  always @(posedge clock) data <= mem[draw_index];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int draw_seen = 0;
  int rise_cyc = 0;
  logic [19:0] exp_q [$];

  always @(posedge clock) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int typ, input bit vis, input bit mov);
    logic [31:0] w;
    w = 32'd0;
    w[31:23] = 9'(x);
    w[18:11] = 8'(y);
    w[3:2]   = 2'(typ);
    w[1]     = vis;
    w[0]     = mov;
    return w;
  endfunction

  task automatic push_block(input int bx, input int by, input logic [2:0] col);
    for (int p = 0; p < 256; p++) begin
      int x = bx + (p % 16);
      int y = by + (p / 16);
      if (x < 320 && y < 240) exp_q.push_back({9'(x), 8'(y), col});
    end
  endtask

  // Scoreboard: every plot pops one expected pixel.
  always @(negedge clock) begin
    if (resetn && plot) begin
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [19:0] want;
        want = exp_q.pop_front();
        check("pixel", {12'd0, vga_x, vga_y, colour}, {12'd0, want});
        $display("plot x=%0d y=%0d colour=%b", vga_x, vga_y, colour);
        if (colour == 3'b011) draw_seen++;
      end
    end
  end

  task automatic wait_pass(input string tag, input int exp_len);
    int n = 0;
    int len = 0;
    while (!draw_stone_flag && n < 3 * FC) begin
      @(negedge clock); #1;
      n++;
    end
    rise_cyc = cyc;
    check({tag, "_start"}, 32'(draw_stone_flag), 32'd1);
    check({tag, "_phase"}, 32'(cyc % FC), 32'd1);
    while (draw_stone_flag && len < 4000) begin
      len++;
      @(negedge clock); #1;
    end
    check({tag, "_len"}, 32'(len), 32'(exp_len));
    check({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clock); #1;
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    $display("pass %s: flag cycles=%0d", tag, len);
  endtask

  initial begin
    int n;
    bit flag_seen;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = mk(100, 50, 1, 1'b1, 1'b0);
    quantity = 4'd1;

    repeat (3) @(negedge clock);
    check("rst_flag",   32'(draw_stone_flag), 32'd0);
    check("rst_index",  32'(draw_index), 32'd0);
    check("rst_x",      32'(vga_x), 32'd0);
    check("rst_y",      32'(vga_y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot",   32'(plot), 32'd0);
    check("rst_done",   32'(done), 32'd0);

    enable = 1'b1;
    resetn = 1'b1;

    // Single gold item, first pass: draw only.
    push_block(100, 50, 3'b110);
    wait_pass("gold", 260);
    check("first_tick_addr", 32'(rise_cyc), 32'(FC + 1));

    // Move right by 4: erase old footprint then redraw (moving bit set, ignored).
    mem[0] = mk(104, 50, 1, 1'b1, 1'b1);
    push_block(100, 50, 3'b000);
    push_block(104, 50, 3'b110);
    wait_pass("move", 516);

    // Vanish: erase only.
    mem[0] = mk(104, 50, 1, 1'b0, 1'b0);
    push_block(104, 50, 3'b000);
    wait_pass("vanish", 260);

    // Still invisible, no shadow: nothing plotted.
    wait_pass("gone", 4);

    // Clip at the bottom-right corner: 10x10 visible pixels.
    mem[0] = mk(310, 230, 0, 1'b1, 1'b0);
    push_block(310, 230, 3'b111);
    wait_pass("clip", 260);

    // Empty list: done without the flag.
    quantity = 4'd0;
    n = 0;
    flag_seen = 1'b0;
    while (!done && n < 3 * FC) begin
      @(negedge clock); #1;
      n++;
      if (draw_stone_flag) flag_seen = 1'b1;
    end
    check("q0_done", 32'(done), 32'd1);
    check("q0_phase", 32'(cyc % FC), 32'd1);
    check("q0_flag", 32'(flag_seen), 32'd0);
    $display("pass q0: done at cycle %0d", cyc);

    // Reset in the middle of DRAW.
    quantity = 4'd1;
    mem[0] = mk(200, 100, 2, 1'b1, 1'b0);
    push_block(310, 230, 3'b000);
    push_block(200, 100, 3'b011);
    draw_seen = 0;
    n = 0;
    while (draw_seen < 100 && n < 4 * FC) begin
      @(negedge clock); #1;
      n++;
    end
    check("rst_reach_draw", 32'(draw_seen), 32'd100);
    resetn = 1'b0;
    @(negedge clock); #1;
    check("midrst_flag", 32'(draw_stone_flag), 32'd0);
    check("midrst_plot", 32'(plot), 32'd0);
    resetn = 1'b1;
    exp_q.delete();
    $display("mid-draw reset applied");

    // Shadow was cleared: the same entry is drawn again with no erase.
    push_block(200, 100, 3'b011);
    wait_pass("after_rst", 260);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
